// File: rtl/ct_l2c_prf_pkg.sv
// Shared definitions for the L2C prefetch request path.
// Contents: request field widths, default queue depth, and prot bit positions.
package ct_l2c_prf_pkg;

  localparam int ADDR_W    = 34;
  localparam int PROT_W    = 3;
  localparam int DEPTH_DEF = 4;

  // prot bit positions
  localparam int PROT_PRIV_BIT  = 0;  // 1 = privileged access
  localparam int PROT_SEC_BIT   = 1;  // 1 = secure access
  localparam int PROT_INSTR_BIT = 2;  // 1 = instruction, 0 = data

  function automatic logic [PROT_W-1:0] make_prot(input logic priv,
                                                  input logic sec,
                                                  input logic instr);
    logic [PROT_W-1:0] p;
    p = '0;
    p[PROT_PRIV_BIT]  = priv;
    p[PROT_SEC_BIT]   = sec;
    p[PROT_INSTR_BIT] = instr;
    return p;
  endfunction

endpackage

// File: rtl/ct_l2c_prf_dedupe.sv
// Duplicate-address detector for the prefetch request queue.
// Ports:
//   ent_vld   - valid bit per queue entry
//   ent_addr  - address per queue entry
//   last_vld  - last-issued history is valid
//   last_addr - address of the most recently issued request
//   req_addr  - incoming request address
//   dup_hit   - incoming address matches a valid entry or the last-issued address
module ct_l2c_prf_dedupe #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 34
) (
  input  logic [DEPTH-1:0]             ent_vld,
  input  logic [DEPTH-1:0][ADDR_W-1:0] ent_addr,
  input  logic                         last_vld,
  input  logic [ADDR_W-1:0]            last_addr,
  input  logic [ADDR_W-1:0]            req_addr,
  output logic                         dup_hit
);

  always_comb begin
    dup_hit = last_vld && (last_addr == req_addr);
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_vld[i] && (ent_addr[i] == req_addr)) dup_hit = 1'b1;
    end
  end

endmodule

// File: rtl/ct_l2c_prf_req_queue.sv
// In-order prefetch request queue between the L2C prefetch generator and
// the CIU prefetch port, with duplicate dropping and flush.
// Ports:
//   l2c_pref_clk, cpurst_b            - clock, async active-low reset
//   pref_q_vld/addr/prot, q_pref_ready - generator push handshake
//   q_ciu_prf_vld/addr/prot, ciu_q_prf_ready - CIU issue handshake
//   ciu_l2c_prf_flush                  - drop all entries and dedupe history
//   q_cnt                              - number of valid entries
//   q_idle                             - empty and no last-issued history
module ct_l2c_prf_req_queue
  import ct_l2c_prf_pkg::*;
#(
  parameter int DEPTH   = DEPTH_DEF,
  parameter int ADDR_W_P = ADDR_W,
  parameter int PROT_W_P = PROT_W
) (
  input  logic                     l2c_pref_clk,
  input  logic                     cpurst_b,
  input  logic                     pref_q_vld,
  input  logic [ADDR_W_P-1:0]      pref_q_addr,
  input  logic [PROT_W_P-1:0]      pref_q_prot,
  output logic                     q_pref_ready,
  output logic                     q_ciu_prf_vld,
  output logic [ADDR_W_P-1:0]      q_ciu_prf_addr,
  output logic [PROT_W_P-1:0]      q_ciu_prf_prot,
  input  logic                     ciu_q_prf_ready,
  input  logic                     ciu_l2c_prf_flush,
  output logic [$clog2(DEPTH):0]   q_cnt,
  output logic                     q_idle
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] CNT_MAX = (PW+1)'(DEPTH);

  logic [PW:0]                          wr_ptr, rd_ptr;
  logic [DEPTH-1:0]                     ent_vld;
  logic [DEPTH-1:0][ADDR_W_P-1:0]       ent_addr;
  logic [DEPTH-1:0][PROT_W_P-1:0]       ent_prot;
  logic [ADDR_W_P-1:0]                  last_addr;
  logic                                 last_vld;
  logic                                 full, empty, dup_hit;
  logic                                 push_acc, push_wr, pop, pop_eff;
  logic [PW-1:0]                        wr_idx, rd_idx;

  assign wr_idx = wr_ptr[PW-1:0];
  assign rd_idx = rd_ptr[PW-1:0];
  assign full   = (wr_ptr[PW] != rd_ptr[PW]) && (wr_idx == rd_idx);
  assign empty  = (wr_ptr == rd_ptr);

  assign q_pref_ready   = !full;
  assign q_ciu_prf_vld  = !empty;
  assign q_ciu_prf_addr = ent_addr[rd_idx];
  assign q_ciu_prf_prot = ent_prot[rd_idx];
  assign q_idle         = empty && !last_vld;

  // Dedupe sees pre-pop state, so the entry leaving this cycle still matches.
  ct_l2c_prf_dedupe #(.DEPTH(DEPTH), .ADDR_W(ADDR_W_P)) u_dedupe (
    .ent_vld   (ent_vld),
    .ent_addr  (ent_addr),
    .last_vld  (last_vld),
    .last_addr (last_addr),
    .req_addr  (pref_q_addr),
    .dup_hit   (dup_hit)
  );

  // Flush swallows any handshake completing in the same cycle.
  assign push_acc = pref_q_vld && q_pref_ready;
  assign push_wr  = push_acc && !dup_hit && !ciu_l2c_prf_flush;
  assign pop      = q_ciu_prf_vld && ciu_q_prf_ready;
  assign pop_eff  = pop && !ciu_l2c_prf_flush;

  // Push and pop never target the same slot: pop needs non-empty, push needs non-full.
  always_ff @(posedge l2c_pref_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      ent_vld  <= '0;
      ent_addr <= '0;
      ent_prot <= '0;
    end else if (ciu_l2c_prf_flush) begin
      ent_vld <= '0;
    end else begin
      if (push_wr) begin
        ent_vld[wr_idx]  <= 1'b1;
        ent_addr[wr_idx] <= pref_q_addr;
        ent_prot[wr_idx] <= pref_q_prot;
      end
      if (pop_eff) ent_vld[rd_idx] <= 1'b0;
    end
  end

  always_ff @(posedge l2c_pref_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      q_cnt  <= '0;
    end else if (ciu_l2c_prf_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      q_cnt  <= '0;
    end else begin
      if (push_wr) wr_ptr <= wr_ptr + 1'b1;
      if (pop_eff) rd_ptr <= rd_ptr + 1'b1;
      case ({push_wr, pop_eff})
        2'b10:   q_cnt <= q_cnt + 1'b1;
        2'b01:   q_cnt <= q_cnt - 1'b1;
        default: q_cnt <= q_cnt;
      endcase
    end
  end

  // History survives drains; only flush or reset forgets it.
  always_ff @(posedge l2c_pref_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      last_vld  <= 1'b0;
      last_addr <= '0;
    end else if (ciu_l2c_prf_flush) begin
      last_vld <= 1'b0;
    end else if (pop_eff) begin
      last_vld  <= 1'b1;
      last_addr <= q_ciu_prf_addr;
    end
  end

  a_cnt_range: assert property (@(posedge l2c_pref_clk) disable iff (!cpurst_b)
    (q_cnt <= CNT_MAX) && !(pop_eff && (q_cnt == '0)));

endmodule

// File: tb/tb_ct_l2c_prf_req_queue.sv
module tb_ct_l2c_prf_req_queue;

  logic        clk;
  logic        rst_b;
  logic        pref_vld;
  logic [33:0] pref_addr;
  logic [2:0]  pref_prot;
  logic        pref_ready;
  logic        ciu_vld;
  logic [33:0] ciu_addr;
  logic [2:0]  ciu_prot;
  logic        ciu_rdy;
  logic        flush;
  logic [2:0]  cnt;
  logic        idle;

  int errors = 0;
  int checks = 0;
  int issued = 0;
  logic [36:0] exp_q[$];

  ct_l2c_prf_req_queue dut (
    .l2c_pref_clk      (clk),
    .cpurst_b          (rst_b),
    .pref_q_vld        (pref_vld),
    .pref_q_addr       (pref_addr),
    .pref_q_prot       (pref_prot),
    .q_pref_ready      (pref_ready),
    .q_ciu_prf_vld     (ciu_vld),
    .q_ciu_prf_addr    (ciu_addr),
    .q_ciu_prf_prot    (ciu_prot),
    .ciu_q_prf_ready   (ciu_rdy),
    .ciu_l2c_prf_flush (flush),
    .q_cnt             (cnt),
    .q_idle            (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One-cycle push; the expectation is queued only when the address is new.
  task automatic push(input logic [33:0] a, input logic [2:0] p, input bit wr);
    pref_vld  = 1'b1;
    pref_addr = a;
    pref_prot = p;
    step();
    pref_vld = 1'b0;
    if (wr) exp_q.push_back({p, a});
  endtask

  initial begin
    rst_b = 1'b0; pref_vld = 1'b0; pref_addr = '0; pref_prot = '0;
    ciu_rdy = 1'b0; flush = 1'b0;

    // Monitor: the handshake seen at negedge completes at the next posedge.
    fork
      forever begin
        logic [36:0] e;
        @(negedge clk);
        if (rst_b && ciu_vld && ciu_rdy && !flush) begin
          checks++;
          issued++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL issue_unexpected: got %0h expected none", {ciu_prot, ciu_addr});
          end else begin
            e = exp_q.pop_front();
            if ({ciu_prot, ciu_addr} !== e) begin
              errors++;
              $display("FAIL issue_order: got %0h expected %0h", {ciu_prot, ciu_addr}, e);
            end
          end
        end
      end
    join_none

    #12;
    chk("rst_ready", pref_ready, 1);
    chk("rst_vld",   ciu_vld,    0);
    chk("rst_cnt",   cnt,        0);
    chk("rst_idle",  idle,       1);
    chk("rst_addr",  ciu_addr,   0);
    step();
    rst_b = 1'b1;
    step();

    // Fill and drain
    for (int i = 0; i < 4; i++) push(34'h100 + 34'(i), 3'(i), 1);
    chk("fill_cnt",   cnt,        4);
    chk("fill_ready", pref_ready, 0);
    chk("fill_vld",   ciu_vld,    1);
    chk("fill_head",  ciu_addr,   34'h100);
    ciu_rdy = 1'b1;
    repeat (4) step();
    chk("drain_vld",  ciu_vld, 0);
    chk("drain_cnt",  cnt,     0);
    chk("drain_idle", idle,    0);
    ciu_rdy = 1'b0;

    // Dedupe against queued entry, then against last-issued
    push(34'h200, 3'b101, 1);
    chk("dup_ready", pref_ready, 1);
    push(34'h200, 3'b101, 0);
    chk("dup_q_cnt", cnt, 1);
    ciu_rdy = 1'b1;
    step();
    ciu_rdy = 1'b0;
    chk("dup_pop_cnt", cnt, 0);
    push(34'h200, 3'b101, 0);
    chk("dup_last_cnt", cnt, 0);
    chk("dup_last_vld", ciu_vld, 0);
    push(34'h201, 3'b010, 1);
    chk("dup_new_cnt", cnt, 1);
    ciu_rdy = 1'b1;
    step();
    ciu_rdy = 1'b0;

    // Simultaneous push and pop at two entries
    push(34'h210, 3'b001, 1);
    push(34'h211, 3'b011, 1);
    chk("sim_pre_cnt", cnt, 2);
    ciu_rdy = 1'b1;
    push(34'h212, 3'b111, 1);
    ciu_rdy = 1'b0;
    chk("sim_cnt",  cnt,      2);
    chk("sim_head", ciu_addr, 34'h211);
    ciu_rdy = 1'b1;
    repeat (2) step();
    chk("sim_drain_cnt", cnt, 0);

    // Pointer wrap with the CIU always ready
    for (int i = 0; i < 10; i++) push(34'h300 + 34'(i), 3'(i), 1);
    step();
    chk("wrap_cnt", cnt,     0);
    chk("wrap_vld", ciu_vld, 0);
    ciu_rdy = 1'b0;

    // Flush with three queued and a same-cycle push and pop
    push(34'h500, 3'b000, 1);
    push(34'h501, 3'b001, 1);
    push(34'h502, 3'b010, 1);
    chk("fl_pre_cnt", cnt, 3);
    pref_vld = 1'b1; pref_addr = 34'h400; pref_prot = 3'b100;
    ciu_rdy = 1'b1; flush = 1'b1;
    exp_q.delete();
    step();
    pref_vld = 1'b0; ciu_rdy = 1'b0; flush = 1'b0;
    chk("fl_cnt",  cnt,     0);
    chk("fl_vld",  ciu_vld, 0);
    chk("fl_idle", idle,    1);
    ciu_rdy = 1'b1;
    push(34'h500, 3'b110, 1);
    chk("fl_repush_vld", ciu_vld, 1);
    step();
    chk("fl_repush_cnt", cnt, 0);
    ciu_rdy = 1'b0;

    // Async reset with the queue half full
    push(34'h600, 3'b000, 1);
    push(34'h601, 3'b001, 1);
    chk("ar_pre_cnt", cnt, 2);
    #2;
    rst_b = 1'b0;
    #1;
    chk("ar_vld",   ciu_vld,    0);
    chk("ar_cnt",   cnt,        0);
    chk("ar_ready", pref_ready, 1);
    chk("ar_idle",  idle,       1);
    exp_q.delete();
    step();
    rst_b = 1'b1;
    step();

    chk("total_issued", issued, 20);
    chk("exp_left", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
